// File: rtl/alu_mem_seq.sv
// alu_mem_seq: sequencer for the ALU + result-memory datapath.
// Streams operand/opcode triples through the ALU into consecutive memory
// addresses, then reads every stored result back on a valid/ready port.
// Optional feature: define ALU_MEM_SEQ_ZCOUNT_EN to add the zero_cnt output,
// which counts written results whose ALU zero flag was set.
module alu_mem_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [2:0]        op_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              zero_flag,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done
`ifdef ALU_MEM_SEQ_ZCOUNT_EN
    ,
    output logic [ADDR_W:0]   zero_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_CAP   = 3'd3,
        ST_RD_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // Memory depth as a job length; longer requests saturate to this.
    localparam logic [ADDR_W:0]   DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_C     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W:0]   idx_r;
    logic [ADDR_W:0]   idx_s;
    logic [ADDR_W:0]   n_r;
    logic [ADDR_W:0]   n_s;
    logic [DATA_W-1:0] rd_data_r;
    logic              busy_r;
    logic              done_r;
    logic              op_ready_r;
    logic              rd_valid_r;
    logic              last_s;

    // The entry at idx is the final one of the job.
    assign last_s = (idx_r == (n_r - ONE_C));

    // Next-state, entry counter and job length decisions.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        n_s     = n_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    n_s   = (len > DEPTH_C) ? DEPTH_C : len;
                    idx_s = CNT_ZERO;
                    if (len == CNT_ZERO) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_WRITE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (op_valid) begin
                    if (last_s) begin
                        idx_s   = CNT_ZERO;
                        state_s = ST_RD_ISSUE;
                    end else begin
                        idx_s   = idx_r + ONE_C;
                        state_s = ST_WRITE;
                    end
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_RD_ISSUE: state_s = ST_RD_CAP;
            ST_RD_CAP:   state_s = ST_RD_HOLD;
            ST_RD_HOLD: begin
                if (rd_ready) begin
                    idx_s = idx_r + ONE_C;
                    if (last_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RD_ISSUE;
                    end
                end else begin
                    state_s = ST_RD_HOLD;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath control: the ALU sees operands only while writing.
    always_comb begin
        alu_a    = DATA_ZERO;
        alu_b    = DATA_ZERO;
        alu_sel  = 3'd0;
        mem_en   = 1'b0;
        mem_addr = ADDR_ZERO;
        case (state_r)
            ST_WRITE: begin
                alu_a    = op_a;
                alu_b    = op_b;
                alu_sel  = op_sel;
                mem_en   = op_valid;
                mem_addr = idx_r[ADDR_W-1:0];
            end
            ST_RD_ISSUE, ST_RD_CAP, ST_RD_HOLD: begin
                mem_addr = idx_r[ADDR_W-1:0];
            end
            default: begin
                mem_addr = ADDR_ZERO;
            end
        endcase
    end

    // State, counters and status flags; flags are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= CNT_ZERO;
            n_r        <= CNT_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            op_ready_r <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            n_r        <= n_s;
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_s == ST_DONE);
            op_ready_r <= (state_s == ST_WRITE);
            rd_valid_r <= (state_s == ST_RD_HOLD);
        end
    end

    // Capture memory read data one cycle after the address was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= DATA_ZERO;
        end else if (state_r == ST_RD_CAP) begin
            rd_data_r <= mem_data;
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign op_ready = op_ready_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign busy     = busy_r;
    assign done     = done_r;

`ifdef ALU_MEM_SEQ_ZCOUNT_EN
    logic [ADDR_W:0] zero_cnt_r;
    logic            zclr_s;
    logic            zinc_s;

    assign zclr_s = (state_r == ST_IDLE) && start;
    assign zinc_s = (state_r == ST_WRITE) && op_valid && zero_flag;

    // Count written results with a zero ALU flag; cleared when a job starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_cnt_r <= CNT_ZERO;
        end else if (zclr_s) begin
            zero_cnt_r <= CNT_ZERO;
        end else if (zinc_s) begin
            zero_cnt_r <= zero_cnt_r + ONE_C;
        end else begin
            zero_cnt_r <= zero_cnt_r;
        end
    end

    assign zero_cnt = zero_cnt_r;
`else
    logic unused_zero_flag_s;
    assign unused_zero_flag_s = zero_flag;
`endif

endmodule

// File: tb/tb_alu_mem_seq.sv
// Self-checking bench for alu_mem_seq: randomized and directed jobs,
// a behavioural ALU/memory environment and a queue-based scoreboard.
module tb_alu_mem_seq;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          op_valid = 1'b0;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic [2:0]    op_sel = '0;
    logic          rd_ready = 1'b0;
    logic          op_ready, mem_en, zero_flag, rd_valid, busy, done;
    logic [DW-1:0] alu_a, alu_b, rd_data, mem_data;
    logic [2:0]    alu_sel;
    logic [AW-1:0] mem_addr;
`ifdef ALU_MEM_SEQ_ZCOUNT_EN
    logic [AW:0]   zero_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_count = 0;
    int rd_count = 0;
    int done_count = 0;
    int job_zero = 0;

    logic [DW-1:0] exp_rd[$];
    int            exp_wa[$];
    int            hs_cyc[$];
    bit            vpat[$];
    bit            rpat[$];
    logic [DW-1:0] da[$];
    logic [DW-1:0] db[$];
    logic [2:0]    ds[$];

    // Environment memory: captured away from the clock edge, applied on it.
    logic [DW-1:0] mem[DEPTH];
    logic          m_en = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_res = '0;
    logic [DW-1:0] rdq = '0;

    alu_mem_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .zero_flag(zero_flag), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .busy(busy), .done(done)
`ifdef ALU_MEM_SEQ_ZCOUNT_EN
        , .zero_cnt(zero_cnt)
`endif
    );

    // Team ALU behaviour: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a, 7 SHR a.
    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return {a[DW-2:0], 1'b0};
            default: return {1'b0, a[DW-1:1]};
        endcase
    endfunction

    assign zero_flag = (alu_f(alu_a, alu_b, alu_sel) == 8'd0);
    assign mem_data  = rdq;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (m_en) mem[m_addr] <= m_res;
            rdq <= mem[m_addr];
        end
    end

    // Monitor: write-address scoreboard, read-data scoreboard, protocol checks.
    initial begin
        logic          hold_v = 1'b0;
        logic [DW-1:0] hold_d = '0;
        logic [AW-1:0] hold_a = '0;
        logic          prev_done = 1'b0;
        forever begin
            @(negedge clk);
            m_en   = mem_en;
            m_addr = mem_addr;
            m_res  = alu_f(alu_a, alu_b, alu_sel);
            if (!rst) begin
                if (mem_en) begin
                    wr_count++;
                    if (exp_wa.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_write: addr %0d, none expected", mem_addr);
                    end else begin
                        check("write_addr", 32'(mem_addr), 32'(exp_wa.pop_front()));
                    end
                end
                if (op_ready) check("mem_en_follows_valid", 32'(mem_en), 32'(op_valid));
                else          check("datapath_zero_outside_write", {18'd0, mem_en, alu_sel, alu_a, alu_b}, 32'd0);
                if (rd_valid) begin
                    if (hold_v) begin
                        check("rd_data_stable", 32'(rd_data), 32'(hold_d));
                        check("rd_addr_stable", 32'(mem_addr), 32'(hold_a));
                    end
                    if (rd_ready) begin
                        rd_count++;
                        hs_cyc.push_back(cyc);
                        hold_v = 1'b0;
                        if (exp_rd.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL unexpected_read: data %0d, none expected", rd_data);
                        end else begin
                            check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
                        end
                    end else begin
                        hold_v = 1'b1;
                        hold_d = rd_data;
                        hold_a = mem_addr;
                    end
                end else begin
                    hold_v = 1'b0;
                end
                if (done) begin
                    done_count++;
                    if (prev_done) check("done_single_cycle", 32'(done), 32'(0));
                end
                prev_done = done;
            end else begin
                hold_v    = 1'b0;
                prev_done = 1'b0;
            end
        end
    end

    // One complete job; called and returns at 1 time unit after a rising edge.
    task automatic run_job(input int jlen, input int vpct, input int rpct, input bit poke);
        int n_exp, wr0, rd0, dn0, i, guard, lat;
        bit full_rate, full_read, poked, v;
        logic [DW-1:0] a, b;
        logic [2:0] s;
        n_exp     = (jlen > DEPTH) ? DEPTH : jlen;
        full_rate = (vpct >= 100) && (vpat.size() == 0);
        full_read = (rpct >= 100) && (rpat.size() == 0);
        wr0 = wr_count; rd0 = rd_count; dn0 = done_count;
        hs_cyc.delete();
        job_zero = 0;
        start = 1'b1;
        len   = 6'(jlen);
        @(posedge clk); #1;
        start = 1'b0;
        len   = 6'($urandom_range(63));
        check("busy_after_start", 32'(busy), 32'd1);
        check("start_to_op_ready", 32'(op_ready), 32'(n_exp > 0));
        i = 0; guard = 0;
        while (i < n_exp && guard < 3000) begin
            if (vpat.size() > 0) v = vpat.pop_front();
            else                 v = ($urandom_range(99) < vpct);
            if (da.size() > 0) begin
                a = da.pop_front(); b = db.pop_front(); s = ds.pop_front();
            end else begin
                a = 8'($urandom); b = 8'($urandom); s = 3'($urandom);
            end
            op_valid = v; op_a = a; op_b = b; op_sel = s;
            check("op_ready_in_write", 32'(op_ready), 32'd1);
            if (v && op_ready) begin
                exp_rd.push_back(alu_f(a, b, s));
                exp_wa.push_back(i % DEPTH);
                if (alu_f(a, b, s) == 8'd0) job_zero++;
                i++;
            end
            @(posedge clk); #1;
            guard++;
        end
        op_valid = 1'b0;
        if (full_rate) check("write_throughput_cycles", 32'(guard), 32'(n_exp));
        rd_ready = 1'b0;
        if (n_exp > 0) begin
            check("op_ready_drop_after_last", 32'(op_ready), 32'd0);
            lat = 1;
            while (!rd_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            check("write_to_rd_valid_latency", 32'(lat), 32'd3);
        end
        guard = 0; poked = 1'b0;
        while ((rd_count - rd0) < n_exp && guard < 3000) begin
            if (rpat.size() > 0) rd_ready = rpat.pop_front();
            else                 rd_ready = ($urandom_range(99) < rpct);
            if (poke && !poked && rd_valid) begin
                start = 1'b1; len = 6'd7; poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b0;
        check("done_after_last_read", 32'(done), 32'd1);
        check("busy_during_done", 32'(busy), 32'd1);
        rd_ready = 1'b0;
        @(posedge clk); #1;
        check("done_falls", 32'(done), 32'd0);
        check("busy_falls", 32'(busy), 32'd0);
        check("no_restart", 32'(op_ready), 32'd0);
        check("write_count", 32'(wr_count - wr0), 32'(n_exp));
        check("read_count", 32'(rd_count - rd0), 32'(n_exp));
        check("done_pulses", 32'(done_count - dn0), 32'd1);
        check("scoreboard_drained", 32'(exp_rd.size() + exp_wa.size()), 32'd0);
        if (full_read && n_exp > 1)
            check("read_throughput", 32'(hs_cyc[hs_cyc.size()-1] - hs_cyc[0]), 32'(3 * (n_exp - 1)));
`ifdef ALU_MEM_SEQ_ZCOUNT_EN
        check("zero_cnt", 32'(zero_cnt), 32'(job_zero));
`endif
    endtask

    initial begin
        int dn0;
        #2;
        check("reset_ctrl_outputs", {27'd0, op_ready, mem_en, rd_valid, busy, done}, 32'd0);
        check("reset_alu_outputs", {13'd0, alu_sel, alu_a, alu_b}, 32'd0);
        check("reset_addr_data", {19'd0, mem_addr, rd_data}, 32'd0);
`ifdef ALU_MEM_SEQ_ZCOUNT_EN
        check("reset_zero_cnt", 32'(zero_cnt), 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", 32'(busy), 32'd0);

        // Directed ADD job: results 15, 21, 0, 0 and two zero results.
        da = '{8'd10, 8'd20, 8'd0, 8'd255};
        db = '{8'd5, 8'd1, 8'd0, 8'd1};
        ds = '{3'd0, 3'd0, 3'd0, 3'd0};
        run_job(4, 100, 100, 1'b0);
        check("directed_zero_results", 32'(job_zero), 32'd2);

        // op_valid pattern 1,0,0,1 with two entries.
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_job(2, 100, 100, 1'b0);

        // rd_ready held low for 5 cycles at the first read.
        rpat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run_job(3, 100, 100, 1'b0);

        // Empty job.
        run_job(0, 100, 100, 1'b0);

        // Over-long job saturates to full memory depth.
        run_job(40, 100, 100, 1'b0);

        // start pulsed while reading is ignored.
        run_job(5, 100, 70, 1'b1);

        // Reset in the middle of writing, then a short job.
        start = 1'b1; len = 6'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            op_valid = 1'b1; op_a = 8'($urandom); op_b = 8'($urandom); op_sel = 3'($urandom);
            exp_rd.push_back(alu_f(op_a, op_b, op_sel));
            exp_wa.push_back(k);
            @(posedge clk); #1;
        end
        dn0 = done_count;
        rst = 1'b1;
        #1;
        check("mid_reset_outputs", {28'd0, busy, op_ready, mem_en, rd_valid}, 32'd0);
        exp_rd.delete();
        exp_wa.delete();
        @(posedge clk); #1;
        rst = 1'b0; op_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_reset_no_done", 32'(done_count - dn0), 32'd0);
        run_job(2, 100, 100, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 8; j++)
            run_job($urandom_range(40, 1), $urandom_range(100, 30), $urandom_range(100, 30), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d failures=%0d)", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
